apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/apb_arb_master.sv | 139 +++++++++++++
 tb/tb_apb_arb_master.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ==========================================================================
// apb_arb_pkg : shared state encoding, defaults and helpers for apb_arb_master
// rev 1.0
// ==========================================================================
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned NUM_REQ         = 2;
  localparam int unsigned WORD_W          = 32;

  // Picks requester idx's word out of a packed {req1, req0} bus.
  function automatic logic [WORD_W-1:0] sel_word(
    input logic [NUM_REQ*WORD_W-1:0] vec,
    input logic                      idx
  );
    return idx ? vec[2*WORD_W-1:WORD_W] : vec[WORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ==========================================================================
// rr_arb2 : two-way round-robin grant, one-hot output, favours the loser
// rev 1.0
// ==========================================================================
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/apb_arb_master.sv
`default_nettype none
// ==========================================================================
// apb_arb_master : two-requester round-robin APB master with wait timeout
// rev 1.0
// ==========================================================================
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*WORD_W-1:0] req_addr,
  input  logic [NUM_REQ*WORD_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic                      rsp_id,
  output logic [WORD_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [WORD_W-1:0]         PADDR,
  output logic [WORD_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PSELx,
  output logic                      PENABLE,
  input  logic                      PREADY,
  input  logic [WORD_W-1:0]         PRDATA,
  input  logic                      PSLVERR
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e          state_q;
  logic                last_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [WORD_W-1:0]   paddr_q;
  logic [WORD_W-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic                rsp_err_q;
  logic [WORD_W-1:0]   rsp_rdata_q;
  logic [CNT_W-1:0]    wait_cnt_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic                gnt_idx;
  logic [CNT_W-1:0]    wait_cnt_d;
  logic                timeout_hit;
  logic [WORD_W-1:0]   rdata_d;

  rr_arb2 u_rr_arb2 (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .grant_o      (arb_grant)
  );

  assign gnt_idx     = arb_grant[1];
  assign req_ready   = (state_q == ST_IDLE) ? arb_grant : 2'b00;
  assign wait_cnt_d  = wait_cnt_q + CNT_W'(1);
  // This cycle would be the TIMEOUT-th consecutive not-ready ACCESS cycle.
  assign timeout_hit = (wait_cnt_d == CNT_W'(TIMEOUT));
  assign rdata_d     = pwrite_q ? '0 : PRDATA;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|arb_grant) begin
            state_q  <= ST_SETUP;
            psel_q   <= 1'b1;
            last_q   <= gnt_idx;
            paddr_q  <= sel_word(req_addr, gnt_idx);
            pwdata_q <= sel_word(req_wdata, gnt_idx);
            pwrite_q <= gnt_idx ? req_write[1] : req_write[0];
          end
        end
        ST_SETUP: begin
          state_q    <= ST_ACCESS;
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= last_q;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= rdata_d;
          end else if (timeout_hit) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= last_q;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// ==========================================================================
// tb_apb_arb_master : scoreboard bench with a cycle-level behavioural model
// rev 1.0
// ==========================================================================
module tb_apb_arb_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic        PWRITE, PSELx, PENABLE;
  logic        PREADY  = 1'b0;
  logic [31:0] PRDATA  = '0;
  logic        PSLVERR = 1'b0;

  apb_arb_master #(.TIMEOUT(TMO)) dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx),
    .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transfer shaping chosen when a transfer is accepted; -1 means random.
  int force_waits = -1;
  int force_err   = -1;
  int cur_waits   = 0;
  bit cur_err     = 1'b0;

  // APB slave: 32 words, cur_waits not-ready ACCESS cycles, noise elsewhere.
  logic [31:0] smem [32];
  initial begin : slave
    int acc;
    acc = 0;
    for (int k = 0; k < 32; k++) smem[k] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (PSELx && PENABLE) begin
        if (acc >= cur_waits) begin
          PREADY  = 1'b1;
          PRDATA  = smem[PADDR[4:0]];
          PSLVERR = cur_err;
          if (PWRITE && !cur_err) smem[PADDR[4:0]] = PWDATA;
        end else begin
          PREADY  = 1'b0;
          PRDATA  = $urandom;
          PSLVERR = 1'($urandom_range(0, 1));
        end
        acc++;
      end else begin
        acc     = 0;
        PREADY  = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
    end
  end

  // Reference model: who may be granted, when the bus is busy, what comes back.
  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    bit          upd;
    logic [4:0]  idx;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb [$];
  exp_t        e_new, e_got;
  logic [31:0] rmem [32];
  int          m_acc   = -10;
  int          m_free  = 0;
  bit          m_last  = 1'b1;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  bit          m_write = 1'b0;
  logic [1:0]  exp_rdy;
  bit          exp_sel, exp_en, due;
  int          gi, w, n;
  bit          er;

  initial begin : monitor
    for (int k = 0; k < 32; k++) rmem[k] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        m_free = 0; m_acc = -10; m_last = 1'b1;
        m_addr = '0; m_wdata = '0; m_write = 1'b0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_psel_penable", 32'({PSELx, PENABLE}), 32'd0);
      end else begin
        exp_rdy = 2'b00;
        if (cyc >= m_free) exp_rdy = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_sel = (cyc > m_acc) && (cyc < m_free);
        exp_en  = (cyc > m_acc + 1) && (cyc < m_free);
        check("psel_penable", 32'({PSELx, PENABLE}), 32'({exp_sel, exp_en}));
        check("paddr", PADDR, m_addr);
        check("pwdata", PWDATA, m_wdata);
        check("pwrite", 32'(PWRITE), 32'(m_write));
        due = (sb.size() > 0) && (cyc == m_free);
        check("rsp_valid", 32'(rsp_valid), 32'(due));
        if (due) begin
          e_got = sb.pop_front();
          if (rsp_valid) begin
            check("rsp_id", 32'(rsp_id), 32'(e_got.id));
            check("rsp_err", 32'(rsp_err), 32'(e_got.err));
            check("rsp_rdata", rsp_rdata, e_got.rdata);
          end
          if (e_got.upd) rmem[e_got.idx] = e_got.wdata;
        end
        if (exp_rdy != 2'b00) begin
          gi      = exp_rdy[1] ? 1 : 0;
          m_last  = exp_rdy[1];
          m_addr  = req_addr[gi*32 +: 32];
          m_wdata = req_wdata[gi*32 +: 32];
          m_write = req_write[gi];
          if (force_waits >= 0) w = force_waits;
          else w = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 3));
          er = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 7) == 0);
          cur_waits = w;
          cur_err   = er;
          n = (w >= TMO) ? TMO : w + 1;
          m_acc  = cyc;
          m_free = cyc + 2 + n;
          e_new.id    = m_last;
          e_new.idx   = m_addr[4:0];
          e_new.wdata = m_wdata;
          if (w >= TMO) begin
            e_new.err = 1'b1; e_new.rdata = '0; e_new.upd = 1'b0;
          end else begin
            e_new.err   = er;
            e_new.rdata = m_write ? 32'd0 : rmem[e_new.idx];
            e_new.upd   = m_write && !er;
          end
          sb.push_back(e_new);
        end
      end
    end
  end

  // Stimulus helpers
  logic [1:0] hs = '0;
  int         hs_cyc = 0;

  task automatic tick();
    @(negedge clk);
    hs     = req_valid & req_ready;
    hs_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && cyc < m_free; k++) tick();
    check("idle_reached", 32'(cyc >= m_free), 32'd1);
  endtask

  task automatic single(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int k;
    set_req(i, wr, a, d);
    k = 0;
    do begin tick(); k++; end while (!hs[i] && k < 50);
    check("accept_seen", 32'(hs[i]), 32'd1);
    req_valid[i] = 1'b0;
    wait_idle();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt, k, prev;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check("reset_psel", 32'(PSELx), 32'd0);
    check("reset_penable", 32'(PENABLE), 32'd0);
    check("reset_pwrite", 32'(PWRITE), 32'd0);
    check("reset_paddr", PADDR, 32'd0);
    check("reset_pwdata", PWDATA, 32'd0);
    check("reset_rsp", 32'({rsp_valid, rsp_err, rsp_id}), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    tick();

    force_waits = 0; force_err = 0;
    single(0, 1'b1, 32'd5, 32'hDEADBEEF);
    single(1, 1'b0, 32'd5, 32'h0);

    set_req(0, 1'b1, 32'h0000_0102, 32'h1111_0000);
    set_req(1, 1'b0, 32'h0000_0203, 32'h2222_0000);
    cnt = 0; k = 0; prev = 0;
    while (cnt < 4 && k < 100) begin
      tick(); k++;
      if (hs != 2'b00) begin
        check("contention_grant", 32'(hs), (cnt % 2 == 1) ? 32'd2 : 32'd1);
        if (cnt > 0) check("contention_spacing", 32'(hs_cyc - prev), 32'd3);
        prev = hs_cyc;
        cnt++;
      end
    end
    check("contention_accepts", 32'(cnt), 32'd4);
    req_valid = 2'b00;
    wait_idle();

    single(1, 1'b1, 32'd9, 32'h12345678);
    force_waits = 3;
    single(0, 1'b0, 32'd9, 32'h0);
    force_waits = 100;
    single(1, 1'b0, 32'd9, 32'h0);
    force_waits = 0; force_err = 1;
    single(0, 1'b1, 32'd3, 32'hAAAA5555);
    force_err = 0;
    single(1, 1'b0, 32'd3, 32'h0);

    // Reset while the slave is stalling; requester 0 holds the last grant.
    force_waits = 100;
    set_req(0, 1'b1, 32'h0000_0011, 32'hCAFEF00D);
    k = 0;
    do begin tick(); k++; end while (!hs[0] && k < 50);
    check("abort_accept_seen", 32'(hs[0]), 32'd1);
    req_valid = 2'b00;
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_psel_penable", 32'({PSELx, PENABLE}), 32'd0);
    tick(); tick();
    rst = 1'b0;
    force_waits = 0;
    set_req(0, 1'b0, 32'h0000_0011, 32'h0);
    set_req(1, 1'b0, 32'h0000_0012, 32'h0);
    k = 0;
    do begin tick(); k++; end while (hs == 2'b00 && k < 50);
    check("post_reset_grant", 32'(hs), 32'd1);
    req_valid = 2'b00;
    wait_idle();

    force_waits = -1; force_err = -1;
    hs = 2'b00;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          a = $urandom;
          a[4:0] = 5'($urandom_range(0, 7));
          set_req(i, 1'($urandom_range(0, 1)), a, $urandom);
        end
      end
      tick();
    end
    req_valid = 2'b00;
    tick();
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
